// File: rtl/miss_handler_arbiter_if.sv
// Miss handler bus: burst request out, line data and completion back.
// The arbiter drives the master side, the AXI burst engine the slave side.
interface miss_handler_arbiter_if #(
  parameter int LINE_SIZE  = 512,
  parameter int ADDR_WIDTH = 27
);
  logic                  mh_start;
  logic                  mh_mode;
  logic [ADDR_WIDTH-1:0] mh_addr;
  logic [LINE_SIZE-1:0]  mh_din;
  logic [LINE_SIZE-1:0]  mh_dout;
  logic                  mh_complete;

  modport master (
    output mh_start,
    output mh_mode,
    output mh_addr,
    output mh_din,
    input  mh_dout,
    input  mh_complete
  );

  modport slave (
    input  mh_start,
    input  mh_mode,
    input  mh_addr,
    input  mh_din,
    output mh_dout,
    output mh_complete
  );
endinterface

// File: rtl/miss_handler_arbiter.sv
// Round-robin share of one miss handler between icache and dcache,
// with dirty-victim writeback sequenced ahead of the refill read.
module miss_handler_arbiter #(
  parameter int LINE_SIZE   = 512,
  parameter int ADDR_WIDTH  = 27,
  parameter int OFFSET_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_ack,
  output logic [LINE_SIZE-1:0]  ic_rdata,
  input  logic                  dc_req,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic                  dc_dirty,
  input  logic [ADDR_WIDTH-1:0] dc_wb_addr,
  input  logic [LINE_SIZE-1:0]  dc_wb_data,
  output logic                  dc_ack,
  output logic [LINE_SIZE-1:0]  dc_rdata,
  miss_handler_arbiter_if.master mh,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    WB_WAIT,
    RD_WAIT,
    RESP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ALIGN =
    {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

  state_t                state;
  state_t                state_n;
  logic                  gnt_dc;
  logic                  last_dc;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  grant;
  logic                  take_dc;
  logic                  go_wb;

  // last_dc=1 after reset hands the first tie to the icache
  always_comb begin
    grant   = ic_req | dc_req;
    take_dc = dc_req & (~ic_req | ~last_dc);
    go_wb   = take_dc & dc_dirty;
    state_n = state;
    unique case (state)
      IDLE:
        if (grant)
          state_n = go_wb ? WB_WAIT : RD_WAIT;
      WB_WAIT:
        if (mh.mh_complete)
          state_n = RD_WAIT;
      RD_WAIT:
        if (mh.mh_complete)
          state_n = RESP;
      RESP:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      gnt_dc      <= 1'b0;
      last_dc     <= 1'b1;
      rd_addr     <= '0;
      mh.mh_start <= 1'b0;
      mh.mh_mode  <= 1'b0;
      mh.mh_addr  <= '0;
      mh.mh_din   <= '0;
      ic_ack      <= 1'b0;
      dc_ack      <= 1'b0;
      ic_rdata    <= '0;
      dc_rdata    <= '0;
    end else begin
      state       <= state_n;
      mh.mh_start <= 1'b0;
      ic_ack      <= 1'b0;
      dc_ack      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            gnt_dc      <= take_dc;
            mh.mh_start <= 1'b1;
            rd_addr     <= (take_dc ? dc_addr : ic_addr) & ALIGN;
            if (go_wb) begin
              mh.mh_mode <= 1'b1;
              mh.mh_addr <= dc_wb_addr & ALIGN;
              mh.mh_din  <= dc_wb_data;
            end else begin
              mh.mh_mode <= 1'b0;
              mh.mh_addr <= (take_dc ? dc_addr : ic_addr) & ALIGN;
            end
          end
        end
        WB_WAIT: begin
          if (mh.mh_complete) begin
            mh.mh_start <= 1'b1;
            mh.mh_mode  <= 1'b0;
            mh.mh_addr  <= rd_addr;
          end
        end
        RD_WAIT: begin
          if (mh.mh_complete) begin
            last_dc <= gnt_dc;
            if (gnt_dc) begin
              dc_rdata <= mh.mh_dout;
              dc_ack   <= 1'b1;
            end else begin
              ic_rdata <= mh.mh_dout;
              ic_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_miss_handler_arbiter.sv
// Bench for miss_handler_arbiter: transaction-queue reference model,
// directed scenarios, then randomized requesters and handler latency.
module tb_miss_handler_arbiter;
  localparam int LS = 512;
  localparam int AW = 27;
  localparam logic [AW-1:0] AMASK = ~27'h3F;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ic_req, dc_req, dc_dirty;
  logic [AW-1:0] ic_addr, dc_addr, dc_wb_addr;
  logic [LS-1:0] dc_wb_data;
  logic          ic_ack, dc_ack, busy;
  logic [LS-1:0] ic_rdata, dc_rdata;

  miss_handler_arbiter_if #(.LINE_SIZE(LS), .ADDR_WIDTH(AW)) mh();

  miss_handler_arbiter #(
    .LINE_SIZE(LS), .ADDR_WIDTH(AW), .OFFSET_BITS(6)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_dirty(dc_dirty),
    .dc_wb_addr(dc_wb_addr), .dc_wb_data(dc_wb_data),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mh(mh), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic check(string name, logic [LS-1:0] act,
                       logic [LS-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: pending bursts of the current transaction in a queue
  typedef struct {
    bit            mode;
    logic [AW-1:0] addr;
    logic [LS-1:0] din;
  } burst_t;

  burst_t        m_q[$];
  bit            m_busy, m_resp, m_last_dc, m_owner_dc;
  logic          e_start, e_mode, e_ic_ack, e_dc_ack, e_busy;
  logic [AW-1:0] e_addr;
  logic [LS-1:0] e_din, e_ic_rdata, e_dc_rdata;

  task automatic issue(burst_t b);
    e_start = 1'b1;
    e_mode  = b.mode;
    e_addr  = b.addr;
    if (b.mode) e_din = b.din;
  endtask

  task automatic model_step();
    burst_t b;
    if (!rstn) begin
      m_q.delete();
      m_busy = 0; m_resp = 0; m_last_dc = 1; m_owner_dc = 0;
      e_start = 0; e_mode = 0; e_addr = '0; e_din = '0;
      e_ic_ack = 0; e_dc_ack = 0;
      e_ic_rdata = '0; e_dc_rdata = '0;
    end else begin
      e_start = 0; e_ic_ack = 0; e_dc_ack = 0;
      if (m_resp) begin
        m_resp = 0;
        m_busy = 0;
      end else if (!m_busy) begin
        if (ic_req || dc_req) begin
          m_owner_dc = dc_req && (!ic_req || !m_last_dc);
          if (m_owner_dc && dc_dirty) begin
            b.mode = 1; b.addr = dc_wb_addr & AMASK; b.din = dc_wb_data;
            m_q.push_back(b);
          end
          b.mode = 0;
          b.addr = (m_owner_dc ? dc_addr : ic_addr) & AMASK;
          b.din  = '0;
          m_q.push_back(b);
          issue(m_q[0]);
          m_busy = 1;
        end
      end else if (mh.mh_complete) begin
        void'(m_q.pop_front());
        if (m_q.size() > 0) begin
          issue(m_q[0]);
        end else begin
          m_last_dc = m_owner_dc;
          m_resp = 1;
          if (m_owner_dc) begin
            e_dc_rdata = mh.mh_dout; e_dc_ack = 1;
          end else begin
            e_ic_rdata = mh.mh_dout; e_ic_ack = 1;
          end
        end
      end
    end
    e_busy = m_busy;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("mh_start", LS'(mh.mh_start), LS'(e_start));
      check("mh_mode", LS'(mh.mh_mode), LS'(e_mode));
      check("mh_addr", LS'(mh.mh_addr), LS'(e_addr));
      check("mh_din", mh.mh_din, e_din);
      check("ic_ack", LS'(ic_ack), LS'(e_ic_ack));
      check("dc_ack", LS'(dc_ack), LS'(e_dc_ack));
      check("ic_rdata", ic_rdata, e_ic_rdata);
      check("dc_rdata", dc_rdata, e_dc_rdata);
      check("busy", LS'(busy), LS'(e_busy));
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [LS-1:0] rand_line();
    logic [LS-1:0] v;
    for (int i = 0; i < LS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  int hcnt = 0;

  // handler: random burst length, spurious completes while idle
  task automatic drive_mh();
    mh.mh_complete = 1'b0;
    if (hcnt > 0) begin
      hcnt--;
      if (hcnt == 0) begin
        mh.mh_complete = 1'b1;
        mh.mh_dout = rand_line();
      end
    end else if ((!m_busy || m_resp) && $urandom_range(0, 7) == 0) begin
      mh.mh_complete = 1'b1;
      mh.mh_dout = rand_line();
    end
    if (mh.mh_start) hcnt = $urandom_range(1, 4);
  endtask

  task automatic drive_req(bit hold);
    if (ic_req && ic_ack) ic_req = 1'b0;
    else if (!ic_req && (hold || $urandom_range(0, 3) == 0)) begin
      ic_req = 1'b1; ic_addr = AW'($urandom);
    end else if (ic_req && !hold && $urandom_range(0, 7) == 0)
      ic_addr = AW'($urandom);
    if (dc_req && dc_ack) dc_req = 1'b0;
    else if (!dc_req && (hold || $urandom_range(0, 3) == 0)) begin
      dc_req = 1'b1; dc_addr = AW'($urandom);
      dc_dirty = 1'($urandom_range(0, 1));
      dc_wb_addr = AW'($urandom); dc_wb_data = rand_line();
    end else if (dc_req && !hold && $urandom_range(0, 7) == 0) begin
      dc_addr = AW'($urandom);
      dc_dirty = 1'($urandom_range(0, 1));
      dc_wb_addr = AW'($urandom); dc_wb_data = rand_line();
    end
  endtask

  logic [LS-1:0] line_a5, line_w, line_d;
  int ack_seq[$];

  initial begin
    rstn = 0; ic_req = 0; dc_req = 0; dc_dirty = 0;
    ic_addr = '0; dc_addr = '0; dc_wb_addr = '0; dc_wb_data = '0;
    mh.mh_complete = 0; mh.mh_dout = '0;
    line_a5 = {16{32'hA5A5A5A5}};
    line_w = rand_line();
    line_d = rand_line();
    step();
    check_en = 1'b1;
    step();
    check("rst_busy", LS'(busy), LS'(0));
    check("rst_start", LS'(mh.mh_start), LS'(0));
    check("rst_ic_ack", LS'(ic_ack), LS'(0));

    // icache refill, address alignment
    rstn = 1; ic_req = 1; ic_addr = 27'h000123F;
    step();
    check("t1_start", LS'(mh.mh_start), LS'(1));
    check("t1_mode", LS'(mh.mh_mode), LS'(0));
    check("t1_addr", LS'(mh.mh_addr), LS'(27'h0001200));
    step(); step();
    mh.mh_complete = 1; mh.mh_dout = line_a5;
    step();
    check("t1_ic_ack", LS'(ic_ack), LS'(1));
    check("t1_ic_rdata", ic_rdata, line_a5);
    check("t1_dc_ack", LS'(dc_ack), LS'(0));
    mh.mh_complete = 0; ic_req = 0;
    step();
    check("t1_idle", LS'(busy), LS'(0));

    // dirty dcache miss: writeback then refill
    dc_req = 1; dc_dirty = 1; dc_wb_addr = 27'h40; dc_addr = 27'h80;
    dc_wb_data = line_w;
    step();
    check("t2_wb_start", LS'(mh.mh_start), LS'(1));
    check("t2_wb_mode", LS'(mh.mh_mode), LS'(1));
    check("t2_wb_addr", LS'(mh.mh_addr), LS'(27'h40));
    check("t2_wb_din", mh.mh_din, line_w);
    step();
    mh.mh_complete = 1;
    step();
    check("t2_rd_start", LS'(mh.mh_start), LS'(1));
    check("t2_rd_mode", LS'(mh.mh_mode), LS'(0));
    check("t2_rd_addr", LS'(mh.mh_addr), LS'(27'h80));
    mh.mh_complete = 0;
    step();
    check("t2_one_start", LS'(mh.mh_start), LS'(0));
    mh.mh_complete = 1; mh.mh_dout = line_d;
    step();
    check("t2_dc_ack", LS'(dc_ack), LS'(1));
    check("t2_dc_rdata", dc_rdata, line_d);
    check("t2_ic_kept", ic_rdata, line_a5);
    mh.mh_complete = 0; dc_req = 0;
    step();

    // spurious complete in IDLE; address change during RD_WAIT
    mh.mh_complete = 1;
    step();
    check("t6_idle_busy", LS'(busy), LS'(0));
    check("t6_idle_ack", LS'({ic_ack, dc_ack}), LS'(0));
    mh.mh_complete = 0;
    dc_req = 1; dc_dirty = 0; dc_addr = 27'h1C0;
    step();
    check("t6_addr", LS'(mh.mh_addr), LS'(27'h1C0));
    dc_addr = 27'h7FFFFFF;
    step();
    check("t6_addr_held", LS'(mh.mh_addr), LS'(27'h1C0));
    mh.mh_complete = 1; mh.mh_dout = rand_line();
    step();
    check("t6_dc_ack", LS'(dc_ack), LS'(1));
    mh.mh_complete = 0; dc_req = 0;
    step();

    // reset during writeback, then restart from the writeback
    dc_req = 1; dc_dirty = 1; dc_wb_addr = 27'h100; dc_addr = 27'h200;
    step(); step();
    rstn = 0;
    step();
    check("t5_busy", LS'(busy), LS'(0));
    check("t5_start", LS'(mh.mh_start), LS'(0));
    check("t5_mode", LS'(mh.mh_mode), LS'(0));
    rstn = 1;
    step();
    check("t5_restart", LS'({mh.mh_start, mh.mh_mode}), LS'(2'b11));
    check("t5_wb_addr", LS'(mh.mh_addr), LS'(27'h100));
    mh.mh_complete = 1;
    step();
    mh.mh_complete = 0;
    step();
    mh.mh_complete = 1;
    step();
    check("t5_dc_ack", LS'(dc_ack), LS'(1));
    mh.mh_complete = 0; dc_req = 0;
    step();

    // both requesters held high from reset: grants alternate
    rstn = 0; hcnt = 0;
    step();
    rstn = 1;
    for (int i = 0; i < 300 && ack_seq.size() < 4; i++) begin
      step();
      if (ic_ack) ack_seq.push_back(0);
      if (dc_ack) ack_seq.push_back(1);
      drive_req(1'b1);
      drive_mh();
    end
    check("t3_ack_count", LS'(ack_seq.size()), LS'(4));
    for (int i = 0; i < ack_seq.size(); i++)
      check("t3_order", LS'(ack_seq[i]), LS'(i % 2));

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step();
      rstn = 1;
      drive_req(1'b0);
      drive_mh();
      if ($urandom_range(0, 299) == 0) begin
        rstn = 0; hcnt = 0; mh.mh_complete = 0;
      end
    end
    ic_req = 0; dc_req = 0; mh.mh_complete = 0;
    step(); step();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
